// File: rtl/amba_axi4_aw_register_slice.sv
`default_nettype none
// amba_axi4_aw_register_slice: two-entry AXI4 AW-channel skid buffer with fully registered
// outputs and a sticky M-side stall watchdog. Rev 1.0
module amba_axi4_aw_register_slice #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int MAXWAIT       = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     S_AWVALID,
  output logic                     S_AWREADY,
  input  logic [ADDRESS_WIDTH-1:0] S_AWADDR,
  input  logic [2:0]               S_AWPROT,
  output logic                     M_AWVALID,
  input  logic                     M_AWREADY,
  output logic [ADDRESS_WIDTH-1:0] M_AWADDR,
  output logic [2:0]               M_AWPROT,
  output logic [1:0]               occupancy,
  output logic                     stall_err
);

  localparam int CNT_W = $clog2(MAXWAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAXWAIT);
  localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_W'(MAXWAIT - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] skid_addr;
  logic [2:0]               skid_prot;
  logic [CNT_W-1:0]         stall_cnt;
  logic                     s_hs;
  logic                     m_hs;

  assign s_hs = S_AWVALID & S_AWREADY;
  assign m_hs = M_AWVALID & M_AWREADY;

  // Outputs are written alongside the state so each one reflects next_state directly.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= EMPTY;
      S_AWREADY <= 1'b0;
      M_AWVALID <= 1'b0;
      M_AWADDR  <= '0;
      M_AWPROT  <= '0;
      skid_addr <= '0;
      skid_prot <= '0;
      occupancy <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          S_AWREADY <= 1'b1;
          if (s_hs) begin
            M_AWADDR  <= S_AWADDR;
            M_AWPROT  <= S_AWPROT;
            M_AWVALID <= 1'b1;
            occupancy <= 2'd1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (s_hs && m_hs) begin
            M_AWADDR <= S_AWADDR;
            M_AWPROT <= S_AWPROT;
          end else if (s_hs) begin
            skid_addr <= S_AWADDR;
            skid_prot <= S_AWPROT;
            S_AWREADY <= 1'b0;
            occupancy <= 2'd2;
            state     <= TWO;
          end else if (m_hs) begin
            M_AWVALID <= 1'b0;
            occupancy <= 2'd0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (m_hs) begin
            M_AWADDR  <= skid_addr;
            M_AWPROT  <= skid_prot;
            S_AWREADY <= 1'b1;
            occupancy <= 2'd1;
            state     <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          S_AWREADY <= 1'b0;
          M_AWVALID <= 1'b0;
          occupancy <= 2'd0;
        end
      endcase
    end
  end

  // Watchdog observes the M side only; it never feeds back into the data path.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else if (M_AWVALID && !M_AWREADY) begin
      if (stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (stall_cnt == CNT_MAX_M1) begin
        stall_err <= 1'b1;
      end
    end else begin
      stall_cnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_amba_axi4_aw_register_slice.sv
`default_nettype none
// tb_amba_axi4_aw_register_slice: directed and random stimulus with a FIFO scoreboard
// for the AW register slice. Rev 1.0
module tb_amba_axi4_aw_register_slice;

  localparam int AW = 32;

  logic          ACLK;
  logic          ARESET;
  logic          S_AWVALID;
  logic          S_AWREADY;
  logic [AW-1:0] S_AWADDR;
  logic [2:0]    S_AWPROT;
  logic          M_AWVALID;
  logic          M_AWREADY;
  logic [AW-1:0] M_AWADDR;
  logic [2:0]    M_AWPROT;
  logic [1:0]    occupancy;
  logic          stall_err;

  amba_axi4_aw_register_slice #(
    .ADDRESS_WIDTH(AW),
    .MAXWAIT      (16)
  ) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .S_AWVALID(S_AWVALID),
    .S_AWREADY(S_AWREADY),
    .S_AWADDR (S_AWADDR),
    .S_AWPROT (S_AWPROT),
    .M_AWVALID(M_AWVALID),
    .M_AWREADY(M_AWREADY),
    .M_AWADDR (M_AWADDR),
    .M_AWPROT (M_AWPROT),
    .occupancy(occupancy),
    .stall_err(stall_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int vectors     = 0;
  int miscompares = 0;
  int accepted    = 0;

  logic [AW+2:0] sb[$];
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr  = '0;
  logic [2:0]    prev_prot  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Monitor: inputs settle 1ns after the rising edge, so the falling edge sees the
  // handshakes that the next rising edge will commit.
  always @(negedge ACLK) begin
    if (ARESET) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", 64'(M_AWVALID), 64'd1);
        chk("stall_payload_held", 64'({M_AWADDR, M_AWPROT}), 64'({prev_addr, prev_prot}));
      end
      prev_stall = M_AWVALID & !M_AWREADY;
      prev_addr  = M_AWADDR;
      prev_prot  = M_AWPROT;
      if (M_AWVALID && M_AWREADY) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'({M_AWADDR, M_AWPROT}), 64'hDEAD_BEEF_DEAD);
        end else begin
          chk("beat_order", 64'({M_AWADDR, M_AWPROT}), 64'(sb.pop_front()));
        end
      end
      if (S_AWVALID && S_AWREADY) begin
        sb.push_back({S_AWADDR, S_AWPROT});
        accepted++;
      end
    end
  end

  initial begin
    int base;
    int cycles;
    ARESET    = 1'b1;
    S_AWVALID = 1'b0;
    S_AWADDR  = '0;
    S_AWPROT  = '0;
    M_AWREADY = 1'b0;

    // Reset values and release
    repeat (2) step();
    chk("rst_m_valid", 64'(M_AWVALID), 64'd0);
    chk("rst_s_ready", 64'(S_AWREADY), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_stall_err", 64'(stall_err), 64'd0);
    chk("rst_m_addr", 64'(M_AWADDR), 64'd0);
    ARESET = 1'b0;
    #1;
    chk("release_s_ready_before_edge", 64'(S_AWREADY), 64'd0);
    step();
    chk("release_s_ready_after_edge", 64'(S_AWREADY), 64'd1);
    chk("release_m_valid", 64'(M_AWVALID), 64'd0);

    // Back-to-back stream with ready tied high
    M_AWREADY = 1'b1;
    S_AWVALID = 1'b1;
    S_AWPROT  = 3'b010;
    for (int i = 0; i < 3; i++) begin
      S_AWADDR = 32'h1000 + 32'(4 * i);
      step();
      chk("stream_addr", 64'(M_AWADDR), 64'(32'h1000 + 32'(4 * i)));
      chk("stream_prot", 64'(M_AWPROT), 64'd2);
      chk("stream_occ", 64'(occupancy), 64'd1);
      chk("stream_s_ready", 64'(S_AWREADY), 64'd1);
      chk("stream_m_valid", 64'(M_AWVALID), 64'd1);
    end
    S_AWVALID = 1'b0;
    step();
    chk("stream_drain_occ", 64'(occupancy), 64'd0);
    chk("stream_drain_valid", 64'(M_AWVALID), 64'd0);

    // Fill both entries while stalled, then drain
    M_AWREADY = 1'b0;
    S_AWVALID = 1'b1;
    S_AWADDR  = 32'hA0;
    S_AWPROT  = 3'b001;
    step();
    chk("fill_occ1", 64'(occupancy), 64'd1);
    S_AWADDR = 32'hB0;
    S_AWPROT = 3'b101;
    step();
    S_AWVALID = 1'b0;
    chk("fill_occ2", 64'(occupancy), 64'd2);
    chk("fill_s_ready", 64'(S_AWREADY), 64'd0);
    chk("fill_addr_a0", 64'(M_AWADDR), 64'hA0);
    repeat (2) step();
    chk("fill_addr_a0_stable", 64'(M_AWADDR), 64'hA0);
    M_AWREADY = 1'b1;
    step();
    chk("drain_addr_b0", 64'(M_AWADDR), 64'hB0);
    chk("drain_prot_b0", 64'(M_AWPROT), 64'd5);
    chk("drain_occ1", 64'(occupancy), 64'd1);
    chk("drain_s_ready", 64'(S_AWREADY), 64'd1);
    step();
    chk("drain_occ0", 64'(occupancy), 64'd0);

    // Stall one short of the limit: no error
    M_AWREADY = 1'b0;
    S_AWVALID = 1'b1;
    S_AWADDR  = 32'hC0;
    S_AWPROT  = 3'b000;
    step();
    S_AWVALID = 1'b0;
    repeat (15) step();
    chk("stall15_err", 64'(stall_err), 64'd0);
    M_AWREADY = 1'b1;
    step();
    chk("stall15_release_err", 64'(stall_err), 64'd0);
    chk("stall15_release_occ", 64'(occupancy), 64'd0);

    // Stall to the limit: sticky error
    M_AWREADY = 1'b0;
    S_AWVALID = 1'b1;
    S_AWADDR  = 32'hD0;
    S_AWPROT  = 3'b011;
    step();
    S_AWVALID = 1'b0;
    repeat (15) step();
    chk("stall16_before_err", 64'(stall_err), 64'd0);
    step();
    chk("stall16_err", 64'(stall_err), 64'd1);
    chk("stall16_addr", 64'(M_AWADDR), 64'hD0);
    M_AWREADY = 1'b1;
    step();
    chk("stall16_delivered_occ", 64'(occupancy), 64'd0);
    chk("stall16_err_sticky", 64'(stall_err), 64'd1);

    // Asynchronous reset with two beats held
    M_AWREADY = 1'b0;
    S_AWVALID = 1'b1;
    S_AWADDR  = 32'hE0;
    step();
    S_AWADDR = 32'hE4;
    step();
    S_AWVALID = 1'b0;
    chk("prereset_occ2", 64'(occupancy), 64'd2);
    #2;
    ARESET = 1'b1;
    sb.delete();
    #1;
    chk("async_rst_m_valid", 64'(M_AWVALID), 64'd0);
    chk("async_rst_s_ready", 64'(S_AWREADY), 64'd0);
    chk("async_rst_occ", 64'(occupancy), 64'd0);
    chk("async_rst_stall_err", 64'(stall_err), 64'd0);
    step();
    ARESET = 1'b0;
    step();
    chk("post_rst_s_ready", 64'(S_AWREADY), 64'd1);
    chk("post_rst_m_valid", 64'(M_AWVALID), 64'd0);
    M_AWREADY = 1'b1;
    S_AWVALID = 1'b1;
    S_AWADDR  = 32'h2000;
    S_AWPROT  = 3'b000;
    step();
    S_AWVALID = 1'b0;
    chk("post_rst_addr", 64'(M_AWADDR), 64'h2000);
    step();
    chk("post_rst_drained", 64'(sb.size()), 64'd0);
    chk("post_rst_occ", 64'(occupancy), 64'd0);

    // Random VALID/READY traffic
    base   = accepted;
    cycles = 0;
    while ((accepted - base) < 10000 && cycles < 40000) begin
      S_AWVALID = ($urandom_range(0, 3) != 0);
      S_AWADDR  = $urandom;
      S_AWPROT  = 3'($urandom_range(0, 7));
      M_AWREADY = ($urandom_range(0, 2) != 0);
      step();
      cycles++;
    end
    chk("random_beats_accepted", 64'((accepted - base) >= 10000), 64'd1);
    S_AWVALID = 1'b0;
    M_AWREADY = 1'b1;
    cycles    = 0;
    while (occupancy != 2'd0 && cycles < 10) begin
      step();
      cycles++;
    end
    step();
    chk("random_drain_occ", 64'(occupancy), 64'd0);
    chk("random_scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
